// File: rtl/id_pkg.sv
// Shared decode definitions: opcodes, instruction field slices, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JMP   = 4'b1100;

    // Instruction field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int R1_HI  = 11;
    localparam int R1_LO  = 8;
    localparam int R2_HI  = 7;
    localparam int R2_LO  = 4;
    localparam int F_HI   = 3;
    localparam int F_LO   = 0;
    localparam int JMP_HI = 11;

    // Control bundle carried in ID/EX; all-zero is a bubble
    typedef struct packed {
        logic valid;
        logic mem_rd;
        logic mem_wr;
        logic reg_we;
        logic branch;
        logic jump;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/reg_file_16x16.sv
// Register file: two async read ports, one sync write port, R0 hardwired to zero.
// Latency: reads combinational with same-cycle write bypass; writes land on the next edge.
// Backpressure: none; a write is accepted whenever wb_we is high.
module reg_file_16x16 #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [1:NREG-1];

    // Storage for R1..R(N-1); R0 has no storage so writes to it vanish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // Read with writeback bypass so decode sees the value being written this cycle
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != '0) rdata_a = (we && waddr == raddr_a) ? wdata : mem[raddr_a];
        if (raddr_b != '0) rdata_b = (we && waddr == raddr_b) ? wdata : mem[raddr_b];
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage: decodes IF/ID, reads registers, detects load-use, registers ID/EX.
// Latency: one cycle from instr_in to ex_*; stall_out is combinational.
// Backpressure: stall_out holds PC and IF/ID for one cycle on a load-use dependency.
// Optional ID_ILLEGAL_TRAP_EN: registers a one-cycle illegal_out pulse on illegal opcodes.
module id_ex_stage
    import id_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [15:0]       instr_in,
    input  logic [15:0]       pc_in,
    input  logic              valid_in,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [3:0]        ex_op,
    output logic [3:0]        ex_func,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [15:0]       ex_pc,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_reg_we,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              illegal_out
);

    logic [3:0]        op;
    logic [REG_AW-1:0] r1;
    logic [REG_AW-1:0] r2;
    logic [3:0]        f;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign op = instr_in[OP_HI:OP_LO];
    assign r1 = instr_in[R1_HI:R1_LO];
    assign r2 = instr_in[R2_HI:R2_LO];
    assign f  = instr_in[F_HI:F_LO];

    // Port A always reads r1, port B always reads r2; decode steers them to A/B
    reg_file_16x16 #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (r1),
        .raddr_b (r2),
        .rdata_a (rd1),
        .rdata_b (rd2)
    );

    ctrl_t             d_ctrl;
    logic [DATA_W-1:0] d_a, d_b, d_imm;
    logic [REG_AW-1:0] d_rd;
    logic [3:0]        d_func;
    logic              use_r1, use_r2, legal;

    // Per-opcode decode; fields an opcode does not define stay zero
    always_comb begin
        d_ctrl = CTRL_BUBBLE;
        d_a    = '0;
        d_b    = '0;
        d_imm  = '0;
        d_rd   = '0;
        d_func = '0;
        use_r1 = 1'b0;
        use_r2 = 1'b0;
        legal  = 1'b1;
        case (op)
            OP_RTYPE: begin
                d_ctrl.reg_we = 1'b1;
                d_a = rd1; d_b = rd2; d_rd = r1; d_func = f;
                use_r1 = 1'b1; use_r2 = 1'b1;
            end
            OP_LW: begin
                d_ctrl.mem_rd = 1'b1; d_ctrl.reg_we = 1'b1;
                d_a = rd2; d_rd = r1;
                d_imm = {{(DATA_W-4){f[3]}}, f};
                use_r2 = 1'b1;
            end
            OP_SW: begin
                d_ctrl.mem_wr = 1'b1;
                d_a = rd2; d_b = rd1;
                d_imm = {{(DATA_W-4){f[3]}}, f};
                use_r1 = 1'b1; use_r2 = 1'b1;
            end
            OP_BEQ: begin
                d_ctrl.branch = 1'b1;
                d_a = rd1; d_b = rd2;
                d_imm = {{(DATA_W-4){f[3]}}, f};
                use_r1 = 1'b1; use_r2 = 1'b1;
            end
            OP_JMP: begin
                d_ctrl.jump = 1'b1;
                d_imm = {{(DATA_W-12){instr_in[JMP_HI]}}, instr_in[JMP_HI:0]};
            end
            default: legal = 1'b0;
        endcase
        d_ctrl.valid = legal;
    end

    ctrl_t ex_ctrl;
    logic  load;

    assign ex_valid  = ex_ctrl.valid;
    assign ex_mem_rd = ex_ctrl.mem_rd;
    assign ex_mem_wr = ex_ctrl.mem_wr;
    assign ex_reg_we = ex_ctrl.reg_we;
    assign ex_branch = ex_ctrl.branch;
    assign ex_jump   = ex_ctrl.jump;

    // Load-use: the load in EX produces a register this instruction reads
    assign stall_out = valid_in & ex_valid & ex_mem_rd & (ex_rd != '0) &
                       ((use_r1 & (r1 == ex_rd)) | (use_r2 & (r2 == ex_rd))) & ~flush;

    assign load = valid_in & legal & ~flush & ~stall_out;

    // ID/EX register: decoded instruction or an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_op   <= '0;
            ex_func <= '0;
            ex_rd   <= '0;
            ex_a    <= '0;
            ex_b    <= '0;
            ex_imm  <= '0;
            ex_pc   <= '0;
        end else if (load) begin
            ex_ctrl <= d_ctrl;
            ex_op   <= op;
            ex_func <= d_func;
            ex_rd   <= d_rd;
            ex_a    <= d_a;
            ex_b    <= d_b;
            ex_imm  <= d_imm;
            ex_pc   <= pc_in;
        end else begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_op   <= '0;
            ex_func <= '0;
            ex_rd   <= '0;
            ex_a    <= '0;
            ex_b    <= '0;
            ex_imm  <= '0;
            ex_pc   <= '0;
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    logic illegal_q;

    // One-cycle trap pulse, registered alongside the bubble it replaces
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal_q <= 1'b0;
        else      illegal_q <= valid_in & ~legal & ~flush & ~stall_out;
    end

    assign illegal_out = illegal_q;
`else
    assign illegal_out = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases plus randomized traffic against a behavioural model.
// Latency: model updates 1 time unit after each rising edge; outputs compared on falling edges.
// Backpressure: random driver re-presents the held instruction whenever the model predicts a stall.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_in = '0;
    logic [15:0] pc_in = '0;
    logic        valid_in = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        stall_out, ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_branch, ex_jump, illegal_out;
    logic [3:0]  ex_op, ex_func, ex_rd;
    logic [15:0] ex_a, ex_b, ex_imm, ex_pc;

    id_ex_stage #(.DATA_W(16), .REG_AW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .instr_in(instr_in), .pc_in(pc_in),
        .valid_in(valid_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_op(ex_op), .ex_func(ex_func),
        .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_we(ex_reg_we),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .illegal_out(illegal_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

`ifdef ID_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Model state: architectural registers and the expected ID/EX contents
    logic [15:0] mregs [16];
    logic        m_valid, m_mrd, m_mwr, m_we, m_br, m_jmp, m_ill;
    logic [3:0]  m_op, m_func, m_rd;
    logic [15:0] m_a, m_b, m_imm, m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_ex();
        m_valid = 0; m_mrd = 0; m_mwr = 0; m_we = 0; m_br = 0; m_jmp = 0; m_ill = 0;
        m_op = 0; m_func = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
    endtask

    task automatic reset_model();
        clear_ex();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
    endtask

    function automatic logic [15:0] mread(input logic [3:0] a);
        if (a == 0) return 16'h0;
        if (wb_we && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

    // Load-use rule evaluated on the live inputs and the modelled EX contents
    function automatic logic model_stall();
        logic [3:0] op, r1, r2;
        logic hit;
        op = instr_in[15:12]; r1 = instr_in[11:8]; r2 = instr_in[7:4];
        case (op)
            4'h0, 4'hB, 4'h4: hit = (r1 == m_rd) || (r2 == m_rd);
            4'h8:             hit = (r2 == m_rd);
            default:          hit = 1'b0;
        endcase
        return valid_in && m_valid && m_mrd && (m_rd != 0) && hit && !flush;
    endfunction

    // What the next rising edge must produce from the current inputs
    task automatic model_edge();
        logic st, legal;
        logic [3:0] op, r1, r2, f;
        if (!rst) begin
            reset_model();
            return;
        end
        st = model_stall();
        op = instr_in[15:12]; r1 = instr_in[11:8]; r2 = instr_in[7:4]; f = instr_in[3:0];
        legal = (op == 4'h0) || (op == 4'h8) || (op == 4'hB) || (op == 4'h4) || (op == 4'hC);
        clear_ex();
        if (valid_in && !flush && !st && legal) begin
            m_valid = 1; m_op = op; m_pc = pc_in;
            case (op)
                4'h0: begin m_a = mread(r1); m_b = mread(r2); m_rd = r1; m_func = f; m_we = 1; end
                4'h8: begin m_a = mread(r2); m_imm = sext4(f); m_rd = r1; m_mrd = 1; m_we = 1; end
                4'hB: begin m_a = mread(r2); m_b = mread(r1); m_imm = sext4(f); m_mwr = 1; end
                4'h4: begin m_a = mread(r1); m_b = mread(r2); m_imm = sext4(f); m_br = 1; end
                default: begin m_imm = {{4{instr_in[11]}}, instr_in[11:0]}; m_jmp = 1; end
            endcase
        end
        m_ill = TRAP && valid_in && !flush && !st && !legal;
        if (wb_we && wb_addr != 0) mregs[wb_addr] = wb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic apply(input logic [15:0] i, input logic [15:0] pc, input logic v,
                         input logic fl, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd);
        instr_in = i; pc_in = pc; valid_in = v; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (cmp_en && rst) begin
            chk("stall", stall_out, model_stall());
            chk("ctrl", {ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_branch, ex_jump},
                        {m_valid, m_mrd, m_mwr, m_we, m_br, m_jmp});
            chk("op_func_rd", {ex_op, ex_func, ex_rd}, {m_op, m_func, m_rd});
            chk("a_b", {ex_a, ex_b}, {m_a, m_b});
            chk("imm_pc", {ex_imm, ex_pc}, {m_imm, m_pc});
            chk("illegal", illegal_out, m_ill);
        end
    end

    initial begin
        logic [15:0] ins;
        logic [3:0]  ops [7];
        logic        st;
        ops[0] = 4'h0; ops[1] = 4'h8; ops[2] = 4'hB; ops[3] = 4'h4;
        ops[4] = 4'hC; ops[5] = 4'hF; ops[6] = 4'h3;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {ex_valid, ex_reg_we, ex_a, ex_pc, illegal_out, stall_out}, 0);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Preload R1=2222, R2=1111
        apply(16'h0000, 16'h0, 0, 0, 1, 4'd1, 16'h2222); tick();
        apply(16'h0000, 16'h0, 0, 0, 1, 4'd2, 16'h1111); tick();

        // Bypass and one-cycle latency
        apply(16'h0230, 16'h0010, 1, 0, 1, 4'd3, 16'h00A5); tick();
        chk("bypass_b", ex_b, 16'h00A5);
        chk("bypass_rd", ex_rd, 4'd2);
        chk("bypass_ctl", {ex_valid, ex_reg_we}, 2'b11);
        chk("bypass_a", ex_a, 16'h1111);

        // Load-use stall for exactly one cycle
        apply(16'h8140, 16'h0012, 1, 0, 0, 0, 0); tick();
        chk("lw_ctl", {ex_mem_rd, ex_rd}, {1'b1, 4'd1});
        apply(16'h0210, 16'h0014, 1, 0, 0, 0, 0); #1;
        chk("lu_stall_on", stall_out, 1'b1);
        tick();
        chk("lu_bubble", ex_valid, 1'b0);
        #1;
        chk("lu_stall_off", stall_out, 1'b0);
        tick();
        chk("lu_issue", {ex_valid, ex_a, ex_b}, {1'b1, 16'h1111, 16'h2222});

        // Flush beats a pending load-use stall
        apply(16'h8140, 16'h0016, 1, 0, 0, 0, 0); tick();
        apply(16'h0210, 16'h0018, 1, 1, 0, 0, 0); #1;
        chk("flush_stall", stall_out, 1'b0);
        tick();
        chk("flush_bubble", ex_valid, 1'b0);
        apply(16'h0000, 16'h0, 0, 0, 0, 0, 0); tick();
        chk("flush_dropped", ex_valid, 1'b0);

        // Immediate sign extension
        apply(16'hCFFE, 16'h0020, 1, 0, 0, 0, 0); tick();
        chk("jmp_imm", {ex_imm, ex_jump}, {16'hFFFE, 1'b1});
        apply(16'hB12F, 16'h0022, 1, 0, 0, 0, 0); tick();
        chk("sw_imm", {ex_imm, ex_mem_wr}, {16'hFFFF, 1'b1});
        chk("sw_ab", {ex_a, ex_b}, {16'h1111, 16'h2222});

        // Illegal opcode
        apply(16'hF000, 16'h0024, 1, 0, 0, 0, 0); tick();
        chk("ill_bubble", ex_valid, 1'b0);
        chk("ill_pulse", illegal_out, TRAP);
        apply(16'h0000, 16'h0, 0, 0, 0, 0, 0); tick();
        chk("ill_clear", illegal_out, 1'b0);

        // Randomized traffic; a stalled instruction is re-presented unchanged
        st = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (st) begin
                flush = ($urandom_range(0, 9) == 0);
            end else begin
                ins = {ops[$urandom_range(0, 6)], 2'b00, 2'($urandom_range(0, 3)),
                       2'b00, 2'($urandom_range(0, 3)), 4'($urandom)};
                if ($urandom_range(0, 3) == 0) ins[11:0] = 12'($urandom);
                instr_in = ins;
                pc_in    = 16'($urandom);
                valid_in = ($urandom_range(0, 7) != 0);
                flush    = ($urandom_range(0, 9) == 0);
            end
            wb_we   = $urandom_range(0, 1);
            wb_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            wb_data = 16'($urandom);
            #1;
            st = model_stall();
            tick();
        end

        // Asynchronous reset while ID/EX holds a real instruction
        apply(16'h0120, 16'h0030, 1, 0, 0, 0, 0); tick();
        chk("pre_reset_valid", ex_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_reset", {ex_valid, ex_reg_we, ex_a, ex_b, ex_pc, stall_out}, 0);
        reset_model();
        tick();
        rst = 1'b1;
        for (int i = 1; i < 16; i++) begin
            apply({4'h0, 4'(i), 4'(i), 4'h0}, 16'h0040, 1, 0, 0, 0, 0);
            tick();
            chk("reg_cleared", {ex_a, ex_b}, 0);
        end
        apply(16'h0000, 16'h0, 0, 0, 0, 0, 0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
